// File: rtl/tsarb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tsarb_pkg
// Description : Shared types and the round-robin pick function for the
//               time-slice arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package tsarb_pkg;

   // Upper bound on requesters the pick function can handle.
   localparam int TSARB_MAX_REQ = 32;
   localparam int TSARB_MAX_W   = 5;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // One-hot winner: first set bit of req at ptr+1, ptr+2, ... modulo num_req.
   function automatic logic [TSARB_MAX_REQ-1:0] rr_pick(
      input logic [TSARB_MAX_REQ-1:0] req,
      input int                       ptr,
      input int                       num_req
   );
      logic [TSARB_MAX_REQ-1:0] l_onehot;
      logic                     l_found;
      logic [TSARB_MAX_W-1:0]   l_idx;
      l_onehot = '0;
      l_found  = 1'b0;
      l_idx    = '0;
      for (int k = 1; k <= TSARB_MAX_REQ; k++) begin
         if (k <= num_req) begin
            l_idx = TSARB_MAX_W'((ptr + k) % num_req);
            if (!l_found && req[l_idx]) begin
               l_onehot[l_idx] = 1'b1;
               l_found         = 1'b1;
            end
         end
      end
      return l_onehot;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tsarb_slice_timer.sv
`default_nettype none
// ============================================================================
// Module      : tsarb_slice_timer
// Description : Slice counter with clear/enable, wrapping at QUANTUM-1.
// Revision    : 1.0 - initial release
// ============================================================================
module tsarb_slice_timer #(
   parameter  int QUANTUM = 8,
   localparam int SLICE_W = $clog2(QUANTUM)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clr_i,
   input  logic               en_i,
   output logic [SLICE_W-1:0] count_o,
   output logic               last_o
);

   localparam logic [SLICE_W-1:0] c_last = SLICE_W'(QUANTUM - 1);

   logic [SLICE_W-1:0] r_count;
   logic               w_last;

   assign w_last = (r_count == c_last);

   // Clear wins over enable so a hand-over always starts a fresh slice.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_count <= '0;
      end else if (clr_i) begin
         r_count <= '0;
      end else if (en_i) begin
         r_count <= w_last ? '0 : r_count + SLICE_W'(1);
      end
   end

   assign count_o = r_count;
   assign last_o  = w_last;

endmodule
`default_nettype wire

// File: rtl/timeslice_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : timeslice_arbiter
// Description : Round-robin arbiter with per-grant time slices; the holder is
//               preempted at slice end only when another requester waits.
//               Optional holder lock enabled by the TSARB_LOCK_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module timeslice_arbiter
   import tsarb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int QUANTUM = 8,
   localparam int IDX_W   = $clog2(NUM_REQ),
   localparam int SLICE_W = $clog2(QUANTUM)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_i,
`ifdef TSARB_LOCK_EN
   input  logic               lock_i,
`endif
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   gnt_idx_o,
   output logic               busy_o,
   output logic [SLICE_W-1:0] slice_o,
   output logic               expire_o
);

   state_e             r_state,   w_state_nxt;
   logic [NUM_REQ-1:0] r_gnt,     w_gnt_nxt;
   logic [IDX_W-1:0]   r_idx,     w_idx_nxt;
   logic [IDX_W-1:0]   r_ptr,     w_ptr_nxt;

   logic [NUM_REQ-1:0] w_req_others;
   logic               w_hold_req;
   logic               w_any_other;
   logic [NUM_REQ-1:0] w_pick;
   logic [IDX_W-1:0]   w_pick_idx;
   logic               w_lock;
   logic               w_tmr_clr;
   logic               w_tmr_en;
   logic               w_tmr_last;
   logic               w_expire;
   logic [SLICE_W-1:0] w_slice;

`ifdef TSARB_LOCK_EN
   assign w_lock = lock_i;
`else
   assign w_lock = 1'b0;
`endif

   tsarb_slice_timer #(
      .QUANTUM (QUANTUM)
   ) u_slice_timer (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (w_tmr_clr),
      .en_i    (w_tmr_en),
      .count_o (w_slice),
      .last_o  (w_tmr_last)
   );

   // The holder is excluded from the pick; with ptr == holder it would be last anyway.
   always_comb begin
      w_req_others = req_i & ~r_gnt;
      w_hold_req   = |(req_i & r_gnt);
      w_any_other  = |w_req_others;
      w_pick       = NUM_REQ'(rr_pick(TSARB_MAX_REQ'(w_req_others), int'(r_ptr), NUM_REQ));
      w_pick_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_pick[i]) begin
            w_pick_idx = w_pick_idx | IDX_W'(i);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_idx_nxt   = r_idx;
      w_ptr_nxt   = r_ptr;
      w_tmr_clr   = 1'b0;
      w_tmr_en    = 1'b0;
      w_expire    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any_other) begin
               w_state_nxt = GRANT;
               w_gnt_nxt   = w_pick;
               w_idx_nxt   = w_pick_idx;
               w_ptr_nxt   = w_pick_idx;
               w_tmr_clr   = 1'b1;
            end
         end
         GRANT: begin
            if (!w_hold_req) begin
               // Release takes precedence over expiry; hand over with no bubble.
               w_tmr_clr = 1'b1;
               if (w_any_other) begin
                  w_gnt_nxt = w_pick;
                  w_idx_nxt = w_pick_idx;
                  w_ptr_nxt = w_pick_idx;
               end else begin
                  w_state_nxt = IDLE;
                  w_gnt_nxt   = '0;
               end
            end else if (w_tmr_last && w_any_other && !w_lock) begin
               w_expire  = 1'b1;
               w_tmr_clr = 1'b1;
               w_gnt_nxt = w_pick;
               w_idx_nxt = w_pick_idx;
               w_ptr_nxt = w_pick_idx;
            end else begin
               w_tmr_en = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_tmr_clr   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_idx   <= '0;
         r_ptr   <= IDX_W'(NUM_REQ - 1);
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_idx   <= w_idx_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   assign gnt_o     = r_gnt;
   assign gnt_idx_o = r_idx;
   assign busy_o    = |r_gnt;
   assign slice_o   = w_slice;
   assign expire_o  = w_expire;

endmodule
`default_nettype wire

// File: tb/tb_timeslice_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_timeslice_arbiter
// Description : Directed scoreboard bench for timeslice_arbiter (4 req, Q=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timeslice_arbiter;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] idx;
      logic [2:0] slice;
      logic       expire;
      string      tag;
   } exp_t;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic [3:0] req_i = '0;
   logic       lock_r = 1'b0;
   logic [3:0] gnt_o;
   logic [1:0] gnt_idx_o;
   logic       busy_o;
   logic [2:0] slice_o;
   logic       expire_o;

   exp_t exp_q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;

   always #5 clk_i = ~clk_i;

   timeslice_arbiter #(
      .NUM_REQ (4),
      .QUANTUM (8)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (req_i),
`ifdef TSARB_LOCK_EN
      .lock_i    (lock_r),
`endif
      .gnt_o     (gnt_o),
      .gnt_idx_o (gnt_idx_o),
      .busy_o    (busy_o),
      .slice_o   (slice_o),
      .expire_o  (expire_o)
   );

   task automatic check(input string tag, input string field,
                        input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got %0h expected %0h (t=%0t)", tag, field, act, exp, $time);
      end
   endtask

   // Monitor: outputs are presented every cycle; compare mid-cycle on the falling edge.
   always @(negedge clk_i) begin
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(e.tag, "gnt",    32'(gnt_o),     32'(e.gnt));
         check(e.tag, "idx",    32'(gnt_idx_o), 32'(e.idx));
         check(e.tag, "slice",  32'(slice_o),   32'(e.slice));
         check(e.tag, "expire", 32'(expire_o),  32'(e.expire));
         check(e.tag, "busy",   32'(busy_o),    32'(|e.gnt));
      end
   end

   task automatic push(input logic [3:0] g, input logic [1:0] ix,
                       input logic [2:0] sl, input logic ex, input string tag);
      exp_q.push_back('{gnt: g, idx: ix, slice: sl, expire: ex, tag: tag});
   endtask

   task automatic step(input logic [3:0] req, input logic lk, input logic [3:0] g,
                       input logic [1:0] ix, input logic [2:0] sl, input logic ex,
                       input string tag);
      @(posedge clk_i);
      #1;
      req_i  = req;
      lock_r = lk;
      push(g, ix, sl, ex, tag);
   endtask

   task automatic apply_reset(input string tag);
      @(posedge clk_i);
      #1;
      rst_i  = 1'b1;
      req_i  = '0;
      lock_r = 1'b0;
      push(4'b0000, 2'd0, 3'd0, 1'b0, tag);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      push(4'b0000, 2'd0, 3'd0, 1'b0, tag);
   endtask

   initial begin
      // Test 1: single requester, slice wraps without expiry.
      apply_reset("t1_reset");
      step(4'b0001, 1'b0, 4'b0000, 2'd0, 3'd0, 1'b0, "t1_idle");
      for (int k = 0; k < 10; k++)
         step(4'b0001, 1'b0, 4'b0001, 2'd0, 3'(k % 8), 1'b0, "t1_hold");
      step(4'b0000, 1'b0, 4'b0001, 2'd0, 3'd2, 1'b0, "t1_release");
      step(4'b0000, 1'b0, 4'b0000, 2'd0, 3'd0, 1'b0, "t1_idle_after");

      // Test 2: two contenders alternate on slice expiry.
      apply_reset("t2_reset");
      step(4'b0011, 1'b0, 4'b0000, 2'd0, 3'd0, 1'b0, "t2_idle");
      for (int k = 0; k < 8; k++)
         step(4'b0011, 1'b0, 4'b0001, 2'd0, 3'(k), (k == 7), "t2_hold0");
      for (int k = 0; k < 8; k++)
         step(4'b0011, 1'b0, 4'b0010, 2'd1, 3'(k), (k == 7), "t2_hold1");
      step(4'b0011, 1'b0, 4'b0001, 2'd0, 3'd0, 1'b0, "t2_back0");

      // Test 3: holder releases at slice 3, hand-over with no bubble, then idle.
      step(4'b0011, 1'b0, 4'b0001, 2'd0, 3'd1, 1'b0, "t3_hold");
      step(4'b0111, 1'b0, 4'b0001, 2'd0, 3'd2, 1'b0, "t3_hold_noise");
      step(4'b0010, 1'b0, 4'b0001, 2'd0, 3'd3, 1'b0, "t3_release");
      step(4'b0010, 1'b0, 4'b0010, 2'd1, 3'd0, 1'b0, "t3_handover");
      step(4'b0000, 1'b0, 4'b0010, 2'd1, 3'd1, 1'b0, "t3_release1");
      step(4'b0000, 1'b0, 4'b0000, 2'd1, 3'd0, 1'b0, "t3_idle");

      // Test 4: ptr=1, requests 3 and 0 -> 3 wins first (wrap-around order).
      step(4'b1001, 1'b0, 4'b0000, 2'd1, 3'd0, 1'b0, "t4_idle");
      step(4'b1001, 1'b0, 4'b1000, 2'd3, 3'd0, 1'b0, "t4_win3");
      step(4'b0001, 1'b0, 4'b1000, 2'd3, 3'd1, 1'b0, "t4_release3");
      step(4'b0001, 1'b0, 4'b0001, 2'd0, 3'd0, 1'b0, "t4_win0");

      // Test 5: reset in the cycle where slice 5 would show; restart from requester 0.
      for (int k = 1; k < 5; k++)
         step(4'b0001, 1'b0, 4'b0001, 2'd0, 3'(k), 1'b0, "t5_hold");
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      push(4'b0000, 2'd0, 3'd0, 1'b0, "t5_midreset");
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      req_i = 4'b1111;
      push(4'b0000, 2'd0, 3'd0, 1'b0, "t5_released");
      step(4'b1111, 1'b0, 4'b0001, 2'd0, 3'd0, 1'b0, "t5_win0");
      step(4'b1111, 1'b0, 4'b0001, 2'd0, 3'd1, 1'b0, "t5_hold0");

`ifdef TSARB_LOCK_EN
      // Test 6: lock suppresses expiry; dropping it expires at slice 7.
      apply_reset("t6_reset");
      step(4'b0011, 1'b1, 4'b0000, 2'd0, 3'd0, 1'b0, "t6_idle");
      for (int k = 0; k < 16; k++)
         step(4'b0011, 1'b1, 4'b0001, 2'd0, 3'(k % 8), 1'b0, "t6_locked");
      for (int k = 0; k < 8; k++)
         step(4'b0011, 1'b0, 4'b0001, 2'd0, 3'(k), (k == 7), "t6_unlocked");
      step(4'b0011, 1'b0, 4'b0010, 2'd1, 3'd0, 1'b0, "t6_handover");
`endif

      // Drain the scoreboard with a bounded wait.
      for (int n = 0; n < 10 && exp_q.size() > 0; n++)
         @(negedge clk_i);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
